// File: rtl/spi_rdid_responder_pkg.sv
// Shared types and constants for the SPI RDID responder.
// Holds the FSM state encoding, the RDID opcode and the default ID bytes.
package spi_rdid_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CMD    = 2'd1,
        ST_RESP   = 2'd2,
        ST_IGNORE = 2'd3
    } state_t;

    localparam logic [7:0] RDID_OPCODE  = 8'h9F;
    localparam logic [7:0] DEF_MAN_ID   = 8'h20;
    localparam logic [7:0] DEF_MEM_TYPE = 8'h20;
    localparam logic [7:0] DEF_MEM_CAP  = 8'h15;

endpackage

// File: rtl/spi_rdid_responder_if.sv
// SPI pins plus command/response status signals of the RDID responder.
interface spi_rdid_responder_if;

    logic       SPICLK;
    logic       SPIMOSI;
    logic       chip_select;
    logic       SPIMISO;
    logic       cmd_strobe;
    logic [7:0] cmd_byte;
    logic       rdid_done;

    modport master (
        output SPICLK, SPIMOSI, chip_select,
        input  SPIMISO, cmd_strobe, cmd_byte, rdid_done
    );

    modport slave (
        input  SPICLK, SPIMOSI, chip_select,
        output SPIMISO, cmd_strobe, cmd_byte, rdid_done
    );

endinterface

// File: rtl/spi_rdid_responder_sync_edge.sv
// 2-flop synchronizer with a delayed copy; emits one-cycle rise/fall pulses
// derived from the synchronized level.
module spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic sync_1;
    logic sync_2;
    logic sync_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1 <= RESET_VAL;
            sync_2 <= RESET_VAL;
            sync_d <= RESET_VAL;
        end else begin
            sync_1 <= async_in;
            sync_2 <= sync_1;
            sync_d <= sync_2;
        end
    end

    assign rise = sync_2 & ~sync_d;
    assign fall = ~sync_2 & sync_d;

endmodule

// File: rtl/spi_rdid_responder.sv
// SPI mode-0 responder: receives a command byte and answers RDID (0x9F)
// with the 3-byte ID, repeating it for as long as the initiator keeps clocking.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | deselected, or waiting for a fresh select falling edge
// ST_CMD    | shifting in the 8-bit command on SPICLK rising edges
// ST_RESP   | shifting out {MAN_ID, MEM_TYPE, MEM_CAP} on falling edges
// ST_IGNORE | unsupported command; bus ignored until deselect
module spi_rdid_responder
    import spi_rdid_responder_pkg::*;
#(
    parameter logic [7:0] MAN_ID   = DEF_MAN_ID,
    parameter logic [7:0] MEM_TYPE = DEF_MEM_TYPE,
    parameter logic [7:0] MEM_CAP  = DEF_MEM_CAP
) (
    input  logic                 CCLK,
    input  logic                 reset,
    spi_rdid_responder_if.slave  spi
);

    localparam logic [23:0] ID_WORD = {MAN_ID, MEM_TYPE, MEM_CAP};

    state_t      state;
    logic        sclk_rise;
    logic        sclk_fall;
    logic [1:0]  mosi_sync;
    logic [1:0]  cs_sync;
    logic [1:0]  sync_fill;
    logic        armed;
    logic [2:0]  bit_cnt;
    logic [7:0]  cmd_shift;
    logic [7:0]  cmd_next;
    logic [4:0]  resp_cnt;
    logic [23:0] resp_shift;
    logic        miso_q;
    logic        strobe_q;
    logic        done_q;
    logic [7:0]  cmd_byte_q;

    spi_sync_edge #(.RESET_VAL(1'b0)) u_sclk_sync (
        .clk      (CCLK),
        .reset    (reset),
        .async_in (spi.SPICLK),
        .rise     (sclk_rise),
        .fall     (sclk_fall)
    );

    assign cmd_next = {cmd_shift[6:0], mosi_sync[1]};

    // sync_fill marks when cs_sync[1] holds a real pin sample rather than its
    // reset value; only a genuine high arms the block, so a select still held
    // low across reset is never mistaken for a new falling edge.
    always_ff @(posedge CCLK) begin
        if (reset) begin
            state      <= ST_IDLE;
            mosi_sync  <= 2'b00;
            cs_sync    <= 2'b11;
            sync_fill  <= 2'b00;
            armed      <= 1'b0;
            bit_cnt    <= 3'd0;
            cmd_shift  <= 8'h00;
            resp_cnt   <= 5'd0;
            resp_shift <= 24'h000000;
            miso_q     <= 1'b0;
            strobe_q   <= 1'b0;
            done_q     <= 1'b0;
            cmd_byte_q <= 8'h00;
        end else begin
            mosi_sync <= {mosi_sync[0], spi.SPIMOSI};
            cs_sync   <= {cs_sync[0], spi.chip_select};
            sync_fill <= {sync_fill[0], 1'b1};
            strobe_q  <= 1'b0;
            done_q    <= 1'b0;

            if (cs_sync[1]) begin
                state    <= ST_IDLE;
                miso_q   <= 1'b0;
                bit_cnt  <= 3'd0;
                resp_cnt <= 5'd0;
                if (sync_fill[1])
                    armed <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (armed) begin
                            state   <= ST_CMD;
                            bit_cnt <= 3'd0;
                            armed   <= 1'b0;
                        end
                    end
                    ST_CMD: begin
                        if (sclk_rise) begin
                            cmd_shift <= cmd_next;
                            bit_cnt   <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                cmd_byte_q <= cmd_next;
                                strobe_q   <= 1'b1;
                                if (cmd_next == RDID_OPCODE) begin
                                    state      <= ST_RESP;
                                    resp_shift <= ID_WORD;
                                    resp_cnt   <= 5'd0;
                                end else begin
                                    state <= ST_IGNORE;
                                end
                            end
                        end
                    end
                    ST_RESP: begin
                        if (sclk_fall) begin
                            miso_q <= resp_shift[23];
                            if (resp_cnt == 5'd23) begin
                                done_q     <= 1'b1;
                                resp_shift <= ID_WORD;
                                resp_cnt   <= 5'd0;
                            end else begin
                                resp_shift <= {resp_shift[22:0], 1'b0};
                                resp_cnt   <= resp_cnt + 5'd1;
                            end
                        end
                    end
                    ST_IGNORE: begin
                        miso_q <= 1'b0;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign spi.SPIMISO    = miso_q;
    assign spi.cmd_strobe = strobe_q;
    assign spi.cmd_byte   = cmd_byte_q;
    assign spi.rdid_done  = done_q;

endmodule

// File: tb/tb_spi_rdid_responder.sv
// Bench for spi_rdid_responder: a bit-level SPI initiator drives directed and
// random transactions; expectations come from a per-transaction bit model.
`timescale 1ns/1ps
module tb_spi_rdid_responder;
    import spi_rdid_responder_pkg::*;

    logic CCLK = 1'b0;
    logic reset = 1'b1;
    always #10 CCLK = ~CCLK;

    spi_rdid_responder_if spi ();

    spi_rdid_responder dut (
        .CCLK  (CCLK),
        .reset (reset),
        .spi   (spi)
    );

    int vec_cnt = 0;
    int err_cnt = 0;
    int strobe_seen = 0;
    int done_seen = 0;
    int strobe_exp = 0;
    int done_exp = 0;
    logic [7:0]  cmd_model = 8'h00;
    logic [23:0] id_word = 24'h202015;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(negedge CCLK) begin
        if (spi.cmd_strobe === 1'b1) strobe_seen++;
        if (spi.rdid_done === 1'b1) done_seen++;
    end

    // One SPI mode-0 bit: MOSI set in the low phase, MISO sampled at the rise.
    task automatic spi_bit(input logic b, output logic m);
        spi.SPIMOSI = b;
        repeat (5) @(negedge CCLK);
        spi.SPICLK = 1'b1;
        m = spi.SPIMISO;
        repeat (5) @(negedge CCLK);
        spi.SPICLK = 1'b0;
    endtask

    function automatic logic exp_miso(input logic [7:0] op, input int i);
        if (i < 8 || op != 8'h9F) return 1'b0;
        return id_word[23 - ((i - 8) % 24)];
    endfunction

    task automatic xact(input logic [7:0] op, input int nbits, input int gap);
        logic m;
        logic b;
        spi.chip_select = 1'b0;
        repeat (5) @(negedge CCLK);
        for (int i = 0; i < nbits; i++) begin
            b = (i < 8) ? op[7 - i] : 1'($urandom);
            spi_bit(b, m);
            check_val("miso_bit", 32'(m), 32'(exp_miso(op, i)));
        end
        if (nbits >= 8) begin
            strobe_exp++;
            cmd_model = op;
            if (op == 8'h9F) done_exp += (nbits - 8) / 24;
        end
        repeat (5) @(negedge CCLK);
        spi.chip_select = 1'b1;
        repeat (gap) @(negedge CCLK);
        check_val("strobe_cnt", 32'(strobe_seen), 32'(strobe_exp));
        check_val("done_cnt", 32'(done_seen), 32'(done_exp));
        check_val("cmd_byte", 32'(spi.cmd_byte), 32'(cmd_model));
        if (gap >= 4) check_val("miso_idle", 32'(spi.SPIMISO), 32'd0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic m;
        logic [7:0] op;
        int nb;
        logic [7:0] rdid_op;
        rdid_op = 8'h9F;
        spi.SPICLK = 1'b0;
        spi.SPIMOSI = 1'b0;
        spi.chip_select = 1'b1;
        repeat (3) @(negedge CCLK);
        reset = 1'b0;
        repeat (4) @(negedge CCLK);

        check_val("rst_miso", 32'(spi.SPIMISO), 32'd0);
        check_val("rst_cmd_byte", 32'(spi.cmd_byte), 32'd0);
        check_val("rst_strobe", 32'(strobe_seen), 32'd0);
        check_val("rst_done", 32'(done_seen), 32'd0);
        check_val("rst_state", 32'(dut.state), 32'(ST_IDLE));

        xact(8'h9F, 32, 6);          // single RDID
        xact(8'h05, 24, 6);          // other opcode, MISO stays low
        xact(8'h9F, 56, 6);          // continued read, ID twice
        xact(8'h9F, 20, 6);          // aborted after 12 response bits
        xact(8'h9F, 32, 6);
        xact(8'h9F, 5, 6);           // aborted mid-command

        // Reset mid-command with select held low: nothing may be accepted.
        spi.chip_select = 1'b0;
        repeat (5) @(negedge CCLK);
        for (int i = 0; i < 4; i++) begin
            spi_bit(rdid_op[7 - i], m);
            check_val("rstcmd_miso", 32'(m), 32'd0);
        end
        reset = 1'b1;
        repeat (2) @(negedge CCLK);
        reset = 1'b0;
        cmd_model = 8'h00;
        for (int i = 4; i < 8; i++) begin
            spi_bit(rdid_op[7 - i], m);
            check_val("rstcmd_miso", 32'(m), 32'd0);
        end
        repeat (5) @(negedge CCLK);
        check_val("rstcmd_strobe", 32'(strobe_seen), 32'(strobe_exp));
        check_val("rstcmd_cmd_byte", 32'(spi.cmd_byte), 32'(cmd_model));
        check_val("rstcmd_state", 32'(dut.state), 32'(ST_IDLE));
        spi.chip_select = 1'b1;
        repeat (6) @(negedge CCLK);
        xact(8'h9F, 32, 6);

        // Back-to-back with a 2-cycle deselect gap.
        xact(8'h9F, 32, 2);
        xact(8'h9F, 32, 6);

        for (int t = 0; t < 12; t++) begin
            op = ($urandom_range(0, 1) == 1) ? 8'h9F : 8'($urandom);
            nb = $urandom_range(0, 64);
            xact(op, nb, $urandom_range(2, 8));
        end
        repeat (6) @(negedge CCLK);
        check_val("final_done", 32'(done_seen), 32'(done_exp));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
